// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame size, sample type and the bit-reversal
// helper used by both the index generator and the reorder buffer.
package fft_pkg;

    localparam int FFT_N    = 3;
    localparam int FFT_DW   = 32;
    localparam int FFT_MAXN = 16;

    typedef logic [FFT_DW-1:0] fft_sample_t;

    // Reverses the low n bits of idx; bits at and above n come back as zero.
    function automatic logic [FFT_MAXN-1:0] rev_bits(input logic [FFT_MAXN-1:0] idx,
                                                     input int n);
        logic [FFT_MAXN-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_MAXN; i++) begin
            if (i < n) begin
                r = {r[FFT_MAXN-2:0], idx[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle around the reorder buffer: bit-reversed input side, natural-order
// output side and the resync error pulse.
interface fft_bitrev_reorder_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          sync_err;

    modport slave (
        input  in_valid, in_first, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, sync_err
    );

    modport master (
        output in_valid, in_first, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, sync_err
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the full flags decide what is valid.
module fft_pingpong_ram #(
    parameter int N  = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [N-1:0]  waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rbank_i,
    input  logic [N-1:0]  raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2][2**N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[rbank_i][raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorder buffer behind the SDF FFT: scatters each bit-reversed frame into one bank
// of a ping-pong RAM and streams the other bank out in natural order.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW
) (
    input logic                 clk,
    input logic                 rst_n,
    fft_bitrev_reorder_if.slave bus
);

    localparam logic [N-1:0] LAST_IDX = '1;

    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [N-1:0]  wcnt_q, wcnt_d;
    logic [N-1:0]  rcnt_q, rcnt_d;
    logic [1:0]    full_q, full_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          sync_err_q, sync_err_d;

    logic          wr_en;
    logic          load;
    logic [N-1:0]  wcnt_eff;
    logic [N-1:0]  wr_addr;
    logic [DW-1:0] rd_data;

    // in_ready depends on registers only, so no combinational path from out_ready.
    assign bus.in_ready  = !full_q[wbank_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.sync_err  = sync_err_q;

    assign wr_en    = bus.in_valid && !full_q[wbank_q];
    assign wcnt_eff = bus.in_first ? '0 : wcnt_q;
    assign wr_addr  = N'(rev_bits(FFT_MAXN'(wcnt_eff), N));
    assign load     = (!out_valid_q || bus.out_ready) && full_q[rbank_q];

    fft_pingpong_ram #(
        .N  (N),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .wbank_i (wbank_q),
        .waddr_i (wr_addr),
        .wdata_i (bus.in_data),
        .rbank_i (rbank_q),
        .raddr_i (rcnt_q),
        .rdata_o (rd_data)
    );

    // A write only ever sets a non-full bank and a read only clears a full one,
    // so the two full-flag updates below never collide on the same bit.
    always_comb begin
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        sync_err_d  = 1'b0;

        if (wr_en) begin
            wcnt_d     = wcnt_eff + 1'b1;
            sync_err_d = bus.in_first && (wcnt_q != '0);
            if (wcnt_eff == LAST_IDX) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
            end
        end

        if (load) begin
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            out_last_d  = (rcnt_q == LAST_IDX);
            rcnt_d      = rcnt_q + 1'b1;
            if (rcnt_q == LAST_IDX) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = !rbank_q;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            sync_err_q  <= sync_err_d;
        end
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Streaming reorder buffer at the output of the radix-2 SDF FFT pipeline.
- The FFT emits each frame in bit-reversed index order. This block writes sample k to address rev_N(k) of a ping-pong RAM, then reads addresses sequentially, so frames leave in natural order.
- Full throughput: one sample per cycle on both sides, with valid/ready flow control.

Parameters:
- N, 3, log2 of frame length; frame = 2^N samples, N >= 1.
- DW, 32, sample width (packed complex {re, im}); opaque to the block.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_first  input  1  marks sample k=0 of a frame; qualified by in_valid & in_ready.
- in_data  input  DW  sample, bit-reversed frame order.
- out_valid  output  1  output sample valid (registered).
- out_ready  input  1  downstream accepts.
- out_data  output  DW  sample, natural order (registered).
- out_last  output  1  marks natural index 2^N-1 (registered).
- sync_err  output  1  one-cycle pulse: in_first arrived mid-frame.

Behaviour:
- Storage: mem[2][2^N] of DW bits. No reset on mem contents.
- State: wbank, rbank (1 bit each); wcnt, rcnt (N bits each); full[1:0].
- Reset values: all state 0, out_valid=0, out_last=0, out_data=0, sync_err=0. Reset mid-frame discards all buffered data.
- in_ready = !full[wbank]. This is combinational from registers only, with no path from out_ready.
- Write on in_valid & in_ready:
  - Address: mem[wbank][rev_N(wcnt_eff)] <= in_data.
  - wcnt_eff = 0 if in_first, else wcnt.
  - wcnt <= wcnt_eff+1, wrapping mod 2^N.
  - If wcnt_eff == 2^N-1: set full[wbank], toggle wbank.
- Resync: in_first with wcnt != 0 discards the partial frame. The write restarts at index 0 in the same bank, and sync_err pulses next cycle. in_first with wcnt == 0 is normal.
- Output load condition: (!out_valid | out_ready) & full[rbank].
  - On load: out_data <= mem[rbank][rcnt], out_valid <= 1, out_last <= (rcnt == 2^N-1), rcnt++.
  - When rcnt == 2^N-1: clear full[rbank], toggle rbank.
- When out_valid & out_ready and no load occurs: out_valid <= 0, out_last <= 0.
- out_data and out_last stay stable while out_valid & !out_ready.
- Set/clear exclusivity: a write sets a non-full bank and a read clears a full bank, so the two never target the same bank in one cycle. Both may happen in the same cycle on different banks.
- Latency:
  - The first output of a frame becomes valid 1 cycle after its last input is accepted, given an idle reader.
  - Minimum latency from in_first to the first out_valid is 2^N cycles.
- Steady state: with continuous input and out_ready=1, output is gap-free and in_ready stays 1.
- Backpressure: with out_ready held low, the writer fills the second bank. in_ready then drops after the 2·2^N-th accepted sample.

Decomposition:
- Shared package fft_pkg holds:
  - constant FFT_N;
  - function rev_bits(N-bit index), the same helper used by the index generator;
  - sample typedef of DW bits.
- Sub-module fft_pingpong_ram (2-bank, 1 write / 1 read, async read, parameters N and DW) holds mem. The control stays in fft_bitrev_reorder.

Test Plan:
- Basic reorder: N=3, out_ready=1, feed 0,4,2,6,1,5,3,7 with in_first on the first sample → out_data 0..7 on consecutive cycles; out_last only with 7; first out_valid exactly 1 cycle after input 7 is accepted.
- Streaming: 4 back-to-back frames, frame f carrying values 8f+rev(k) → output 0..31 in order, in_ready=1 throughout, no output bubbles after the first.
- Backpressure: hold out_ready=0 and stream input → in_ready falls after 16 accepted samples. Release out_ready → 16 outputs in order; out_data stays stable while stalled.
- Random stall: random in_valid/out_ready over 50 frames → output equals the scoreboard's natural-order stream; no loss or duplication.
- Resync: send 3 samples, then in_first plus a full frame 0,4,2,6,1,5,3,7 → sync_err pulses once; output is exactly 0..7; the partial frame never appears.
- Reset mid-operation: assert rst_n low after 5 outputs of a frame → out_valid=0 and in_ready=1 immediately. After release, a new frame reorders correctly with no stale data emitted.
